// File: rtl/counter_bank_pkg.sv
// Shared constants and helpers for the prescaled counter bank.
package counter_bank_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prescaled_counter_channel.sv
// One counter channel: prescaler, divisor register, count and sticky overflow.
module prescaled_counter_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int PSW     = 8,
    parameter int DIV_RST = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             hit,
    input  logic             clr_hit,
    input  logic             div_we_hit,
    input  logic [PSW-1:0]   Div_data,
    input  logic             Mode,
    input  logic             Ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    logic [PSW-1:0] pre;
    logic [PSW-1:0] div;

    // Later assignments win, so a fresh overflow beats Ovf_clr.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
            pre <= '0;
            div <= PSW'(DIV_RST);
            ovf <= 1'b0;
        end else begin
            if (Ovf_clr) begin
                ovf <= 1'b0;
            end
            if (clr_hit) begin
                cnt <= '0;
                pre <= '0;
                ovf <= 1'b0;
            end else if (div_we_hit) begin
                div <= Div_data;
                pre <= '0;
            end else if (hit) begin
                if (pre >= div) begin
                    pre <= '0;
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        ovf <= 1'b1;
                        if (Mode == MODE_WRAP) begin
                            cnt <= '0;
                        end
                    end
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prescaled_counter_bank.sv
// Bank of NCH prescaled event counters steered by a shared En/Sel pair.
module prescaled_counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int WIDTH   = 64,
    parameter int PSW     = 8,
    parameter int SELW    = clog2_min1(NCH),
    parameter int DIV_RST = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 En,
    input  logic [SELW-1:0]      Sel,
    input  logic                 Mode,
    input  logic                 Div_we,
    input  logic [PSW-1:0]       Div_data,
    input  logic                 Clr,
    input  logic                 Ovf_clr,
    output logic [NCH*WIDTH-1:0] Count,
    output logic [NCH-1:0]       Ovf
);

    // Out-of-range selects must not alias onto a real channel.
    logic sel_valid;
    assign sel_valid = (int'(Sel) < NCH);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic sel_c;
        assign sel_c = sel_valid && (int'(Sel) == c);

        prescaled_counter_channel #(
            .WIDTH   (WIDTH),
            .PSW     (PSW),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .Clk        (Clk),
            .Reset      (Reset),
            .hit        (En & sel_c),
            .clr_hit    (Clr & sel_c),
            .div_we_hit (Div_we & sel_c),
            .Div_data   (Div_data),
            .Mode       (Mode),
            .Ovf_clr    (Ovf_clr),
            .cnt        (Count[c*WIDTH +: WIDTH]),
            .ovf        (Ovf[c])
        );
    end

endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Directed bench: a default 2x64 bank and a narrow 3x4 bank for edge cases.
module tb_prescaled_counter_bank;
    import counter_bank_pkg::*;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         En;
    logic [1:0]   sel;
    logic         Mode;
    logic         Div_we;
    logic [7:0]   div_data;
    logic         Clr;
    logic         Ovf_clr;
    logic [127:0] count_a;
    logic [1:0]   ovf_a;
    logic [11:0]  count_b;
    logic [2:0]   ovf_b;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    prescaled_counter_bank #(
        .NCH(2), .WIDTH(64), .PSW(8), .SELW(1), .DIV_RST(0)
    ) u_a (
        .Clk(Clk), .Reset(Reset), .En(En), .Sel(sel[0]), .Mode(Mode),
        .Div_we(Div_we), .Div_data(div_data), .Clr(Clr),
        .Ovf_clr(Ovf_clr), .Count(count_a), .Ovf(ovf_a)
    );

    prescaled_counter_bank #(
        .NCH(3), .WIDTH(4), .PSW(8), .SELW(2), .DIV_RST(0)
    ) u_b (
        .Clk(Clk), .Reset(Reset), .En(En), .Sel(sel), .Mode(Mode),
        .Div_we(Div_we), .Div_data(div_data), .Clr(Clr),
        .Ovf_clr(Ovf_clr), .Count(count_b), .Ovf(ovf_b)
    );

    task automatic idle();
        Reset = 1'b0; En = 1'b0; sel = 2'd0; Div_we = 1'b0;
        div_data = 8'd0; Clr = 1'b0; Ovf_clr = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        En = 1'b1;
        Div_we = 1'b1;
        div_data = 8'd7;
        cyc(1);
        idle();
    endtask

    task automatic events(input logic [1:0] s, input int n);
        sel = s;
        En = 1'b1;
        cyc(n);
        En = 1'b0;
    endtask

    task automatic test_reset();
        Mode = MODE_WRAP;
        do_reset();
        total++;
        if (count_a !== 128'd0 || ovf_a !== 2'b00) begin
            bad++;
            $display("FAIL reset_a count=%h ovf=%b exp 0", count_a, ovf_a);
        end
        total++;
        if (count_b !== 12'd0 || ovf_b !== 3'b000) begin
            bad++;
            $display("FAIL reset_b count=%h ovf=%b exp 0", count_b, ovf_b);
        end
    endtask

    task automatic test_default_div();
        do_reset();
        events(2'd0, 5);
        total++;
        if (count_a[63:0] !== 64'd5 || count_a[127:64] !== 64'd0) begin
            bad++;
            $display("FAIL div0 ch0=%0d ch1=%0d exp 5/0",
                     count_a[63:0], count_a[127:64]);
        end
        total++;
        if (ovf_a !== 2'b00) begin
            bad++;
            $display("FAIL div0_ovf got=%b exp 00", ovf_a);
        end
    endtask

    task automatic test_prescale();
        do_reset();
        sel = 2'd1; Div_we = 1'b1; div_data = 8'd3;
        cyc(1);
        idle();
        events(2'd1, 9);
        total++;
        if (count_a[127:64] !== 64'd2 || count_a[63:0] !== 64'd0) begin
            bad++;
            $display("FAIL div4_9 ch1=%0d ch0=%0d exp 2/0",
                     count_a[127:64], count_a[63:0]);
        end
        events(2'd1, 2);
        total++;
        if (count_a[127:64] !== 64'd2) begin
            bad++;
            $display("FAIL div4_11 ch1=%0d exp 2", count_a[127:64]);
        end
        events(2'd1, 1);
        total++;
        if (count_a[127:64] !== 64'd3) begin
            bad++;
            $display("FAIL div4_12 ch1=%0d exp 3", count_a[127:64]);
        end
        sel = 2'd1; En = 1'b1; Reset = 1'b1;
        cyc(1);
        idle();
        total++;
        if (count_a !== 128'd0 || ovf_a !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid count=%h ovf=%b exp 0", count_a, ovf_a);
        end
    endtask

    task automatic test_wrap_sat();
        Mode = MODE_WRAP;
        do_reset();
        events(2'd0, 15);
        total++;
        if (count_b[3:0] !== 4'd15 || ovf_b !== 3'b000) begin
            bad++;
            $display("FAIL wrap_pre ch0=%0d ovf=%b exp 15/000",
                     count_b[3:0], ovf_b);
        end
        events(2'd0, 1);
        total++;
        if (count_b[3:0] !== 4'd0 || ovf_b !== 3'b001) begin
            bad++;
            $display("FAIL wrap ch0=%0d ovf=%b exp 0/001", count_b[3:0], ovf_b);
        end
        Mode = MODE_SAT;
        do_reset();
        events(2'd0, 16);
        total++;
        if (count_b[3:0] !== 4'd15 || ovf_b !== 3'b001) begin
            bad++;
            $display("FAIL sat ch0=%0d ovf=%b exp 15/001", count_b[3:0], ovf_b);
        end
        events(2'd0, 2);
        total++;
        if (count_b[3:0] !== 4'd15) begin
            bad++;
            $display("FAIL sat_hold ch0=%0d exp 15", count_b[3:0]);
        end
        Mode = MODE_WRAP;
    endtask

    task automatic test_ovf_clr_race();
        Mode = MODE_WRAP;
        do_reset();
        events(2'd1, 16);
        events(2'd0, 15);
        total++;
        if (ovf_b !== 3'b010) begin
            bad++;
            $display("FAIL race_pre ovf=%b exp 010", ovf_b);
        end
        sel = 2'd0; En = 1'b1; Ovf_clr = 1'b1;
        cyc(1);
        idle();
        total++;
        if (ovf_b !== 3'b001 || count_b[3:0] !== 4'd0) begin
            bad++;
            $display("FAIL race ovf=%b ch0=%0d exp 001/0", ovf_b, count_b[3:0]);
        end
        Ovf_clr = 1'b1;
        cyc(1);
        idle();
        total++;
        if (ovf_b !== 3'b000) begin
            bad++;
            $display("FAIL ovf_clr ovf=%b exp 000", ovf_b);
        end
    endtask

    task automatic test_clr_priority();
        do_reset();
        sel = 2'd0; Div_we = 1'b1; div_data = 8'd1;
        cyc(1);
        idle();
        events(2'd0, 3);
        total++;
        if (count_b[3:0] !== 4'd1) begin
            bad++;
            $display("FAIL clr_pre ch0=%0d exp 1", count_b[3:0]);
        end
        sel = 2'd0; En = 1'b1; Clr = 1'b1; Div_we = 1'b1; div_data = 8'd5;
        cyc(1);
        idle();
        total++;
        if (count_b[3:0] !== 4'd0) begin
            bad++;
            $display("FAIL clr ch0=%0d exp 0", count_b[3:0]);
        end
        events(2'd0, 1);
        total++;
        if (count_b[3:0] !== 4'd0) begin
            bad++;
            $display("FAIL clr_pre0 ch0=%0d exp 0", count_b[3:0]);
        end
        events(2'd0, 1);
        total++;
        if (count_b[3:0] !== 4'd1) begin
            bad++;
            $display("FAIL clr_div ch0=%0d exp 1", count_b[3:0]);
        end
    endtask

    task automatic test_out_of_range();
        Mode = MODE_WRAP;
        do_reset();
        events(2'd0, 3);
        events(2'd1, 1);
        events(2'd2, 2);
        total++;
        if (count_b !== 12'h213) begin
            bad++;
            $display("FAIL oor_pre count=%h exp 213", count_b);
        end
        sel = 2'd3; En = 1'b1; Clr = 1'b1; Div_we = 1'b1; div_data = 8'd3;
        cyc(1);
        Clr = 1'b0; Div_we = 1'b0;
        cyc(3);
        idle();
        total++;
        if (count_b !== 12'h213 || ovf_b !== 3'b000) begin
            bad++;
            $display("FAIL oor count=%h ovf=%b exp 213/000", count_b, ovf_b);
        end
        events(2'd0, 1);
        events(2'd2, 1);
        total++;
        if (count_b !== 12'h314) begin
            bad++;
            $display("FAIL oor_div count=%h exp 314", count_b);
        end
    endtask

    initial begin
        idle();
        Mode = MODE_WRAP;
        cyc(2);
        test_reset();
        test_default_div();
        test_prescale();
        test_wrap_sat();
        test_ovf_clr_race();
        test_clr_priority();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prescaled_counter_bank.md
Name: prescaled_counter_bank

Overview:
- Bank of NCH independent event counters. Each channel has its own runtime-programmable prescaler, wrap/saturate overflow handling and a sticky overflow flag.
- A shared En/Sel pair steers each count event to one channel.
- Generalises the fixed two-channel, fixed divide-by-4 performance counter used in the datapath test harness.
- Used for cycle/event statistics collection.

Parameters:
- NCH, 2, number of channels (≥1)
- WIDTH, 64, counter width per channel
- PSW, 8, prescaler divisor register width
- SELW, $clog2(NCH) (min 1), width of Sel
- DIV_RST, 0, reset value of every channel's divisor register (divide-by DIV_RST+1)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high; clears all state
- En  in  1  count event qualifier
- Sel  in  SELW  channel receiving the event / Div_we / Clr
- Mode  in  1  0 = wrap on overflow, 1 = saturate at all-ones (global, sampled every cycle)
- Div_we  in  1  write Div_data into divisor of channel Sel
- Div_data  in  PSW  new divisor value (divide ratio = Div_data+1)
- Clr  in  1  clear count, prescaler and Ovf of channel Sel
- Ovf_clr  in  1  clear all sticky Ovf flags
- Count  out  NCH*WIDTH  channel c count at bits [c*WIDTH +: WIDTH]
- Ovf  out  NCH  sticky overflow flag per channel

Behaviour:
- Reset (Clk edge with Reset=1): all counts=0, prescalers=0, Ovf=0, divisors=DIV_RST. Reset overrides every other input.
- Per channel c, state: cnt[WIDTH], pre[PSW], div[PSW], ovf.
- Per-channel priority (only when Sel==c): Clr > Div_we > count event.
  - Clr: cnt<=0, pre<=0, ovf<=0; div unchanged.
  - Div_we: div<=Div_data, pre<=0; no count event that cycle.
  - Count event (En=1, Clr=0, Div_we=0):
    - pre==div: pre<=0, tick.
    - pre!=div: pre<=pre+1.
    - pre>div (possible only transiently, never after a Div_we): treated as pre==div.
- Tick handling:
  - cnt != all-ones: cnt<=cnt+1.
  - cnt == all-ones, Mode=0: cnt<=0, ovf<=1.
  - cnt == all-ones, Mode=1: cnt holds, ovf<=1.
- Channels with Sel!=c hold all state, except for Ovf_clr.
- Sel ≥ NCH: En, Div_we and Clr have no effect on any channel.
- Ovf_clr clears every ovf. A new overflow in the same cycle wins: that channel's ovf=1.
- Latency: Count and Ovf are registered outputs that update on the edge the event is sampled, visible in the following cycle. No combinational input-to-output path.
- div=0 gives one tick per enabled event. div=3 gives one tick per 4 events.
- Count arithmetic is unsigned modulo 2^WIDTH. Saturate mode never wraps.

Decomposition:
- Package counter_bank_pkg: localparams MODE_WRAP=1'b0, MODE_SAT=1'b1; function clog2_min1.
- Sub-module prescaled_counter_channel: one channel's cnt/pre/div/ovf plus the priority logic. Ports: Clk, Reset, hit (En & Sel==c), clr_hit, div_we_hit, Div_data, Mode, Ovf_clr, cnt, ovf.
- Top level: instantiate the sub-module NCH times in a generate loop. Owns Sel decode (with range check) and Count concatenation.

Test Plan:
1. Reset then default div=0, NCH=2: En=1, Sel=0 for 5 cycles -> Count ch0=5, ch1=0, Ovf=0.
2. Div_we Sel=1, Div_data=3; then En=1, Sel=1 for 9 cycles -> ch1=2, pre=1. Matches legacy divide-by-4. Reset mid-sequence -> all zero next cycle.
3. WIDTH=4, Mode=0, ch0 at 15, one event -> ch0=0, Ovf[0]=1. Repeat with Mode=1 -> ch0 stays 15, Ovf[0]=1.
4. Same cycle: Ovf_clr=1 and ch0 overflow event -> Ovf[0]=1. Next cycle Ovf_clr alone -> Ovf=0.
5. Sel=0 with En=1, Clr=1, Div_we=1 together -> ch0 count=0, pre=0, div unchanged.
6. NCH=3 (SELW=2), Sel=3, En/Div_we/Clr=1 -> no channel state changes.
